// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe_if
// Description : Valid/ready operand and result bundle for the alu_pipe datapath.
// Revision    : 1.0  initial release
// ============================================================================
interface alu_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] Ain;
   logic [WIDTH-1:0] Bin;
   logic [2:0]       ALUop;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             Z;
   logic             N;
   logic             V;

   modport master (
      output in_valid, Ain, Bin, ALUop, out_ready,
      input  in_ready, out_valid, out, Z, N, V
   );

   modport slave (
      input  in_valid, Ain, Bin, ALUop, out_ready,
      output in_ready, out_valid, out, Z, N, V
   );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Registered ALU with valid/ready handshakes and Z/N/V flags.
//               Define ALU_PIPE_MUL_EN to build the iterative multiplier.
// Revision    : 1.0  initial release
// ============================================================================
module alu_pipe #(
   parameter int WIDTH = 16
) (
   input  logic       clk,
   input  logic       reset,
   alu_pipe_if.slave  bus
);
   localparam logic [2:0] c_op_add  = 3'b000;
   localparam logic [2:0] c_op_sub  = 3'b001;
   localparam logic [2:0] c_op_and  = 3'b010;
   localparam logic [2:0] c_op_notb = 3'b011;
   localparam logic [2:0] c_op_or   = 3'b100;
   localparam logic [2:0] c_op_xor  = 3'b101;
`ifdef ALU_PIPE_MUL_EN
   localparam logic [2:0] c_op_mul  = 3'b110;
   localparam int         CNTW      = $clog2(WIDTH);
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
`ifdef ALU_PIPE_MUL_EN
      S_BUSY = 2'd1,
`endif
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_out;
   logic             r_z;
   logic             r_n;
   logic             r_v;
   logic             r_out_valid;

   logic             w_in_ready;
   logic             w_accept;
   logic [WIDTH-1:0] w_res;
   logic             w_v;

`ifdef ALU_PIPE_MUL_EN
   logic [2*WIDTH-1:0] r_ma;
   logic [WIDTH-1:0]   r_mb;
   logic [2*WIDTH-1:0] r_acc;
   logic [CNTW-1:0]    r_cnt;
   logic [2*WIDTH-1:0] w_step;

   assign w_step = r_acc + (r_mb[0] ? r_ma : '0);
`endif

   assign w_in_ready = !reset && (r_state == S_IDLE || (r_state == S_DONE && bus.out_ready));
   assign w_accept   = bus.in_valid && w_in_ready;

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out       = r_out;
   assign bus.Z         = r_z;
   assign bus.N         = r_n;
   assign bus.V         = r_v;

   // Single-cycle result; op 110 falls through to pass-A when no multiplier is built.
   always_comb begin
      w_res = bus.Ain;
      w_v   = 1'b0;
      case (bus.ALUop)
         c_op_add: begin
            w_res = bus.Ain + bus.Bin;
            w_v   = (bus.Ain[WIDTH-1] == bus.Bin[WIDTH-1]) && (w_res[WIDTH-1] != bus.Ain[WIDTH-1]);
         end
         c_op_sub: begin
            w_res = bus.Ain - bus.Bin;
            w_v   = (bus.Ain[WIDTH-1] != bus.Bin[WIDTH-1]) && (w_res[WIDTH-1] != bus.Ain[WIDTH-1]);
         end
         c_op_and:  w_res = bus.Ain & bus.Bin;
         c_op_notb: w_res = ~bus.Bin;
         c_op_or:   w_res = bus.Ain | bus.Bin;
         c_op_xor:  w_res = bus.Ain ^ bus.Bin;
         default:   w_res = bus.Ain;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_out       <= '0;
         r_z         <= 1'b0;
         r_n         <= 1'b0;
         r_v         <= 1'b0;
         r_out_valid <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
         r_ma        <= '0;
         r_mb        <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
`ifdef ALU_PIPE_MUL_EN
                  if (bus.ALUop == c_op_mul) begin
                     r_ma        <= {{WIDTH{1'b0}}, bus.Ain};
                     r_mb        <= bus.Bin;
                     r_acc       <= '0;
                     r_cnt       <= CNTW'(WIDTH - 1);
                     r_out_valid <= 1'b0;
                     r_state     <= S_BUSY;
                  end else
`endif
                  begin
                     r_out       <= w_res;
                     r_z         <= (w_res == '0);
                     r_n         <= w_res[WIDTH-1];
                     r_v         <= w_v;
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end
               end else if (r_state == S_DONE && bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
`ifdef ALU_PIPE_MUL_EN
            S_BUSY: begin
               // One partial product per edge; the final step writes the result directly.
               r_acc <= w_step;
               r_ma  <= r_ma << 1;
               r_mb  <= r_mb >> 1;
               if (r_cnt == '0) begin
                  r_out       <= w_step[WIDTH-1:0];
                  r_z         <= (w_step[WIDTH-1:0] == '0);
                  r_n         <= w_step[WIDTH-1];
                  r_v         <= |w_step[2*WIDTH-1:WIDTH];
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - CNTW'(1);
               end
            end
`endif
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe
// Description : Self-checking bench for alu_pipe (WIDTH=16), directed plus random.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_pipe;
   localparam int W = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   alu_pipe_if #(.WIDTH(W)) bus ();
   alu_pipe #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk16(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference result from the arithmetic definition of each op.
   function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                                  output logic [W-1:0] r, output bit v, output bit mul);
      int sa, sb, s;
      logic [63:0] p;
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      r   = a;
      v   = 1'b0;
      mul = 1'b0;
      p   = '0;
      case (op)
         3'd0: begin s = sa + sb; r = a + b; v = (s > 32767) || (s < -32768); end
         3'd1: begin s = sa - sb; r = a - b; v = (s > 32767) || (s < -32768); end
         3'd2: r = a & b;
         3'd3: r = ~b;
         3'd4: r = a | b;
         3'd5: r = a ^ b;
`ifdef ALU_PIPE_MUL_EN
         3'd6: begin p = 64'(a) * 64'(b); r = p[W-1:0]; v = (p >> W) != 0; mul = 1'b1; end
`endif
         default: r = a;
      endcase
   endfunction

   bit           m_valid = 1'b0;
   logic [W-1:0] m_out   = '0;
   bit           m_z = 1'b0, m_n = 1'b0, m_v = 1'b0;
   int           m_busy  = 0;
   logic [W-1:0] p_out   = '0;
   bit           p_v     = 1'b0;

   // Compare against the model every cycle, then advance the model to the next edge.
   always @(negedge clk) begin
      bit           exp_ready;
      logic [W-1:0] r;
      bit           v, mul;
      if (cyc > 0) begin
         exp_ready = !reset && ((m_busy == 0 && !m_valid) || (m_valid && bus.out_ready));
         chkb("in_ready", bus.in_ready, exp_ready);
         chkb("out_valid", bus.out_valid, m_valid);
         chk16("out", bus.out, m_out);
         chkb("Z", bus.Z, m_z);
         chkb("N", bus.N, m_n);
         chkb("V", bus.V, m_v);
         if (reset) begin
            m_valid = 1'b0; m_out = '0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0; m_busy = 0;
         end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_valid = 1'b1; m_out = p_out; m_z = (p_out == 0); m_n = p_out[W-1]; m_v = p_v;
            end
         end else if (bus.in_valid && exp_ready) begin
            ref_op(bus.Ain, bus.Bin, bus.ALUop, r, v, mul);
            if (mul) begin
               m_busy = W; m_valid = 1'b0; p_out = r; p_v = v;
            end else begin
               m_valid = 1'b1; m_out = r; m_z = (r == 0); m_n = r[W-1]; m_v = v;
            end
         end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Present an op and hold it until accepted; returns edges spent waiting.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op, output int waited);
      bit ok;
      bus.Ain = a; bus.Bin = b; bus.ALUop = op; bus.in_valid = 1'b1;
      ok = 1'b0;
      waited = 0;
      while (!ok && waited < 64) begin
         @(negedge clk);
         ok = bus.in_ready;
         waited++;
         sync();
      end
      bus.in_valid = 1'b0;
      if (!ok) chkb("accept_timeout", 1'b0, 1'b1);
   endtask

   task automatic wait_res(output int n);
      n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (!bus.out_valid) chkb("result_timeout", 1'b0, 1'b1);
   endtask

   function automatic logic [W-1:0] rnd();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return 16'h7FFF;
         3:       return 16'h8000;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int  n, w;
      bit  acc_prev;
      bus.in_valid = 1'b0; bus.Ain = '0; bus.Bin = '0; bus.ALUop = '0; bus.out_ready = 1'b1;
      reset = 1'b1;
      repeat (3) sync();
      reset = 1'b0;
      @(negedge clk);
      chkb("ready_after_reset", bus.in_ready, 1'b1);
      chkb("valid_after_reset", bus.out_valid, 1'b0);
      chk16("out_after_reset", bus.out, 16'h0000);
      sync();

      issue(16'h7FFF, 16'h0001, 3'd0, w);
      wait_res(n);
      chk16("add_latency", 16'(n), 16'd0);
      chk16("add_out", bus.out, 16'h8000);
      chkb("add_N", bus.N, 1'b1);
      chkb("add_V", bus.V, 1'b1);
      chkb("add_Z", bus.Z, 1'b0);
      sync();
      @(negedge clk);
      chkb("add_valid_one_cycle", bus.out_valid, 1'b0);
      sync();

      issue(16'h0005, 16'h0005, 3'd1, w);
      wait_res(n);
      chk16("sub_out", bus.out, 16'h0000);
      chkb("sub_Z", bus.Z, 1'b1);
      chkb("sub_N", bus.N, 1'b0);
      chkb("sub_V", bus.V, 1'b0);
      sync();

      issue(16'h1234, 16'h00FF, 3'd3, w);
      wait_res(n);
      chk16("notb_out", bus.out, 16'hFF00);
      chkb("notb_N", bus.N, 1'b1);
      sync();

      issue(16'hF0F0, 16'h0FF0, 3'd5, w); chk16("b2b_xor_wait", 16'(w), 16'd1);
      issue(16'hF0F0, 16'h0FF0, 3'd4, w); chk16("b2b_or_wait", 16'(w), 16'd1);
      issue(16'hF0F0, 16'h0FF0, 3'd2, w); chk16("b2b_and_wait", 16'(w), 16'd1);
      issue(16'hF0F0, 16'h0FF0, 3'd7, w); chk16("b2b_pass_wait", 16'(w), 16'd1);
      wait_res(n);
      chk16("b2b_pass_out", bus.out, 16'hF0F0);
      sync();

      issue(16'h1234, 16'h1111, 3'd0, w);
      bus.out_ready = 1'b0;
      bus.Ain = 16'h0010; bus.Bin = 16'h0001; bus.ALUop = 3'd1; bus.in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chkb("bp_in_ready", bus.in_ready, 1'b0);
         chkb("bp_out_valid", bus.out_valid, 1'b1);
         chk16("bp_out", bus.out, 16'h2345);
         sync();
      end
      bus.out_ready = 1'b1;
      issue(16'h0010, 16'h0001, 3'd1, w);
      chk16("bp_release_wait", 16'(w), 16'd1);
      wait_res(n);
      chk16("bp_sub_out", bus.out, 16'h000F);
      sync();

`ifdef ALU_PIPE_MUL_EN
      issue(16'h0012, 16'h0034, 3'd6, w);
      wait_res(n);
      chk16("mul_latency", 16'(n), 16'd16);
      chk16("mul_out", bus.out, 16'h03A8);
      chkb("mul_V", bus.V, 1'b0);
      sync();
      issue(16'h1000, 16'h0010, 3'd6, w);
      wait_res(n);
      chk16("mul_ovf_out", bus.out, 16'h0000);
      chkb("mul_ovf_Z", bus.Z, 1'b1);
      chkb("mul_ovf_V", bus.V, 1'b1);
      sync();
      issue(16'h0012, 16'h0034, 3'd6, w);
      repeat (4) sync();
`else
      issue(16'hBEEF, 16'h0000, 3'd6, w);
      wait_res(n);
      chk16("op6_latency", 16'(n), 16'd0);
      chk16("op6_out", bus.out, 16'hBEEF);
      chkb("op6_V", bus.V, 1'b0);
      sync();
      bus.out_ready = 1'b0;
      issue(16'h0002, 16'h0002, 3'd0, w);
`endif
      reset = 1'b1;
      sync();
      reset = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chkb("rst_mid_valid", bus.out_valid, 1'b0);
      chk16("rst_mid_out", bus.out, 16'h0000);
      chkb("rst_mid_ready", bus.in_ready, 1'b1);
      sync();
      issue(16'h0002, 16'h0003, 3'd0, w);
      wait_res(n);
      chk16("post_rst_latency", 16'(n), 16'd0);
      chk16("post_rst_out", bus.out, 16'h0005);
      sync();

      acc_prev = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if (!bus.in_valid || acc_prev) begin
            if ($urandom_range(0, 3) != 0) begin
               bus.in_valid = 1'b1;
               bus.Ain      = rnd();
               bus.Bin      = rnd();
               bus.ALUop    = 3'($urandom_range(0, 7));
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 149) == 0);
         @(negedge clk);
         acc_prev = bus.in_valid && bus.in_ready;
         sync();
      end
      bus.in_valid = 1'b0;
      reset = 1'b0;
      repeat (3) sync();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
